rx_block_lock_ctrl: RTL and testbench

//  Block-lock controller for the 64b/66b receive path (IEEE 802.3 Cl.49 lock FSM style).

---
 rtl/rx_pcs_pkg.sv | 23 ++
 rtl/rx_hiber_mon.sv | 72 +++++++
 rtl/rx_block_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_rx_block_lock_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pcs_pkg.sv
// Shared definitions for the 64b/66b receive PCS control logic.
//   SYNC_DATA / SYNC_CTRL : the two legal 2-bit sync headers
//   HIBER_THRESH          : invalid headers per BER window that flag high BER
//   lock_state_e          : block-lock FSM state encoding
//   sh_is_valid()         : returns 1 for a legal sync header
package rx_pcs_pkg;

  localparam logic [1:0] SYNC_DATA    = 2'b01;
  localparam logic [1:0] SYNC_CTRL    = 2'b10;
  localparam int         HIBER_THRESH = 16;

  typedef enum logic [1:0] {
    ST_RESET_CNT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP      = 2'd2,
    ST_SLIP_WAIT = 2'd3
  } lock_state_e;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_hiber_mon.sv
// High-BER monitor: counts invalid sync headers over windows of P_BER_WINDOW
// valid beats while block lock is held. A window closing with HIBER_THRESH or
// more invalid headers raises hi_ber_o for the following window; a window
// closing below the threshold clears it. Dropping en_i clears the counters but
// leaves hi_ber_o untouched until a later window closes.
// Ports:
//   clk_i        in  RX user clock
//   rst_i        in  synchronous reset, active high
//   en_i         in  block lock; counting runs only while high
//   hdr_valid_i  in  header beat qualifier
//   hdr_bad_i    in  current beat carries an invalid header
//   hi_ber_o     out high-BER flag (registered)
module rx_hiber_mon
  import rx_pcs_pkg::*;
#(
  parameter int P_BER_WINDOW = 39062
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic hdr_valid_i,
  input  logic hdr_bad_i,
  output logic hi_ber_o
);

  localparam int WIN_W = $clog2(P_BER_WINDOW + 1);
  localparam int BAD_W = $clog2(HIBER_THRESH + 1);
  localparam logic [WIN_W-1:0] WIN_INIT   = WIN_W'(P_BER_WINDOW - 1);
  localparam logic [BAD_W-1:0] BAD_THRESH = BAD_W'(HIBER_THRESH);

  logic [WIN_W-1:0] win_q, win_d;
  logic [BAD_W-1:0] bad_q, bad_d, bad_inc;
  logic             hi_ber_q, hi_ber_d;

  // Saturate at the threshold; only "reached it or not" matters.
  assign bad_inc = (hdr_bad_i && (bad_q != BAD_THRESH)) ? bad_q + BAD_W'(1) : bad_q;

  always_comb begin
    win_d    = win_q;
    bad_d    = bad_q;
    hi_ber_d = hi_ber_q;
    if (!en_i) begin
      // Holding the window at its start value makes it restart at lock acquisition.
      win_d = WIN_INIT;
      bad_d = '0;
    end else if (hdr_valid_i) begin
      if (win_q == '0) begin
        win_d    = WIN_INIT;
        bad_d    = '0;
        hi_ber_d = (bad_inc == BAD_THRESH);
      end else begin
        win_d = win_q - WIN_W'(1);
        bad_d = bad_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q    <= '0;
      bad_q    <= '0;
      hi_ber_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      bad_q    <= bad_d;
      hi_ber_q <= hi_ber_d;
    end
  end

  assign hi_ber_o = hi_ber_q;

endmodule

// File: rtl/rx_block_lock_ctrl.sv
// Block-lock controller for the 64b/66b receive path. Tests sync headers from
// the RX gearbox in windows of P_SH_CNT_MAX beats, requests single-cycle
// gearbox slips until alignment is found, and reports block lock.
// Optional feature macro: RX_HIBER_MON_EN (instantiates rx_hiber_mon; when
// undefined hi_ber_o is tied low).
// Ports:
//   clk_i            in   RX user clock
//   rst_i            in   synchronous reset, active high
//   rxheader_i       in   [1:0] sync header from gearbox
//   rxheadervalid_i  in   rxheader_i qualifier
//   rxgearboxslip_o  out  one-cycle slip request to gearbox
//   block_lock_o     out  block lock status
//   slip_count_o     out  [7:0] slips since reset, saturating
//   hi_ber_o         out  high-BER flag
//
// state        | meaning
// ST_RESET_CNT | clear window counters, start a new test window
// ST_TEST_SH   | count headers on valid beats, decide lock / slip
// ST_SLIP      | slip pulse cycle, lock dropped
// ST_SLIP_WAIT | let the gearbox settle, headers ignored
module rx_block_lock_ctrl
  import rx_pcs_pkg::*;
#(
  parameter int P_SH_CNT_MAX     = 64,
  parameter int P_SH_INVALID_MAX = 16,
  parameter int P_SLIP_WAIT      = 32,
  parameter int P_BER_WINDOW     = 39062
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] rxheader_i,
  input  logic       rxheadervalid_i,
  output logic       rxgearboxslip_o,
  output logic       block_lock_o,
  output logic [7:0] slip_count_o,
  output logic       hi_ber_o
);

  localparam int SH_W   = $clog2(P_SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(P_SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(P_SLIP_WAIT + 1);
  localparam logic [SH_W-1:0]   SH_MAX    = SH_W'(P_SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(P_SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(P_SLIP_WAIT - 1);

  lock_state_e       state_q, state_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d, inv_cnt_inc;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic [7:0]        slip_cnt_q, slip_cnt_d;
  logic              hdr_bad, win_end, inv_limit;

  assign hdr_bad     = rxheadervalid_i & ~sh_is_valid(rxheader_i);
  // inv_cnt never passes INV_MAX: reaching it while locked (or any bad header
  // while unlocked) leaves ST_TEST_SH.
  assign sh_cnt_inc  = sh_cnt_q + SH_W'(1);
  assign inv_cnt_inc = inv_cnt_q + INV_W'(hdr_bad);
  assign win_end     = (sh_cnt_inc == SH_MAX);
  assign inv_limit   = (inv_cnt_inc == INV_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RESET_CNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET_CNT: state_d = ST_TEST_SH;
      ST_TEST_SH: begin
        if (rxheadervalid_i) begin
          // Slip is checked first so it wins over a simultaneous window end.
          if (hdr_bad && (!lock_q || inv_limit)) state_d = ST_SLIP;
          else if (win_end)                      state_d = ST_RESET_CNT;
        end
      end
      ST_SLIP:      state_d = ST_SLIP_WAIT;
      ST_SLIP_WAIT: if (wait_q == '0) state_d = ST_RESET_CNT;
      default:      state_d = ST_RESET_CNT;
    endcase
  end

  // Registered outputs are computed from the transition so the slip pulse and
  // the lock drop appear together, one cycle after the offending beat.
  always_comb begin
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_d     = wait_q;
    lock_d     = lock_q;
    slip_cnt_d = slip_cnt_q;
    slip_d     = (state_d == ST_SLIP);
    case (state_q)
      ST_RESET_CNT: begin
        sh_cnt_d  = '0;
        inv_cnt_d = '0;
      end
      ST_TEST_SH: begin
        if (rxheadervalid_i) begin
          sh_cnt_d  = sh_cnt_inc;
          inv_cnt_d = inv_cnt_inc;
          if (win_end && (inv_cnt_inc == '0)) lock_d = 1'b1;
        end
      end
      ST_SLIP_WAIT: if (wait_q != '0) wait_d = wait_q - WAIT_W'(1);
      default: ;
    endcase
    if (slip_d) begin
      lock_d = 1'b0;
      wait_d = WAIT_INIT;
      if (slip_cnt_q != 8'hFF) slip_cnt_d = slip_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      wait_q     <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      slip_cnt_q <= 8'h00;
    end else begin
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_q     <= wait_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign rxgearboxslip_o = slip_q;
  assign block_lock_o    = lock_q;
  assign slip_count_o    = slip_cnt_q;

`ifdef RX_HIBER_MON_EN
  rx_hiber_mon #(
    .P_BER_WINDOW (P_BER_WINDOW)
  ) u_hiber_mon (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (lock_q),
    .hdr_valid_i (rxheadervalid_i),
    .hdr_bad_i   (hdr_bad),
    .hi_ber_o    (hi_ber_o)
  );
`else
  assign hi_ber_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_block_lock_ctrl.sv
`timescale 1ns/1ps
module tb_rx_block_lock_ctrl;
  import rx_pcs_pkg::*;

  localparam int CNT_MAX   = 64;
  localparam int SLIP_WAIT = 32;
  localparam int BER_WIN   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] hdr = 2'b01;
  logic       hv  = 1'b0;
  logic       slip, lock, hiber;
  logic [7:0] scnt;

  int n_chk  = 0;
  int n_pass = 0;

  rx_block_lock_ctrl #(
    .P_SH_CNT_MAX     (CNT_MAX),
    .P_SH_INVALID_MAX (16),
    .P_SLIP_WAIT      (SLIP_WAIT),
    .P_BER_WINDOW     (BER_WIN)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rxheader_i      (hdr),
    .rxheadervalid_i (hv),
    .rxgearboxslip_o (slip),
    .block_lock_o    (lock),
    .slip_count_o    (scnt),
    .hi_ber_o        (hiber)
  );

  always #2 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One cycle: drive inputs, let the edge pass, sample 1 ns later.
  task automatic beat(input logic [1:0] h, input logic v);
    hdr = h;
    hv  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    hv  = 1'b0;
    hdr = SYNC_DATA;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_rst_lock"}, lock, 0);
    check({tag, "_rst_slip"}, slip, 0);
    check({tag, "_rst_scnt"}, scnt, 0);
    check({tag, "_rst_hiber"}, hiber, 0);
    rst = 1'b0;
    beat(SYNC_DATA, 1'b0);  // first cycle after reset is ST_RESET_CNT
  endtask

  // One test window: an idle cycle (covers ST_RESET_CNT) then CNT_MAX beats.
  // n_bad invalid headers placed at the start or end of the window. After a
  // slip the window is abandoned and the FSM is left to settle.
  task automatic run_window(input int n_bad, input bit at_end,
                            output int slips_seen, output bit drop_ok);
    int  first_bad;
    bit  slipped;
    bit  bad;
    first_bad  = at_end ? CNT_MAX - n_bad + 1 : 1;
    slipped    = 1'b0;
    slips_seen = 0;
    drop_ok    = 1'b1;
    beat(SYNC_DATA, 1'b0);
    for (int b = 1; b <= CNT_MAX; b++) begin
      bad = (n_bad > 0) && (b >= first_bad) && (b < first_bad + n_bad);
      if (slipped) beat(SYNC_DATA, 1'b0);
      else         beat(bad ? 2'b11 : SYNC_DATA, 1'b1);
      if (slip) begin
        slips_seen++;
        slipped = 1'b1;
        if (lock !== 1'b0) drop_ok = 1'b0;
      end
    end
    if (slipped) begin
      for (int c = 0; c < SLIP_WAIT + 8; c++) begin
        beat(SYNC_DATA, 1'b0);
        if (slip) slips_seen++;
      end
    end
  endtask

  typedef struct {
    int n_bad;
    bit at_end;
    bit exp_lock;
    int exp_slips;
  } win_t;

  win_t recs[11];
  int   exp_scnt;
  int   seen;
  bit   dok;
  int   gap;
  bit   got;
  int   m;
  int   nslip;
  logic [1:0] h;

  initial begin
    recs = '{
      '{0,  1'b0, 1'b1, 0},  // clean window acquires lock
      '{15, 1'b0, 1'b1, 0},  // 15 bad while locked: held
      '{0,  1'b0, 1'b1, 0},
      '{16, 1'b0, 1'b0, 1},  // 16th bad mid-window: slip
      '{0,  1'b0, 1'b1, 0},  // relock
      '{16, 1'b1, 1'b0, 1},  // 16th bad on beat 64: slip beats window end
      '{1,  1'b0, 1'b0, 1},  // unlocked: first bad header slips
      '{0,  1'b0, 1'b1, 0},
      '{15, 1'b1, 1'b1, 0},  // 15 bad ending on beat 64: held
      '{1,  1'b0, 1'b1, 0},
      '{16, 1'b0, 1'b0, 1}
    };

    // 70 clean beats: lock exactly at beat 64
    do_reset("clean");
    nslip = 0;
    for (int b = 1; b <= 70; b++) begin
      beat(SYNC_DATA, 1'b1);
      if (slip) nslip++;
      if (b == 63) check("clean_lock_b63", lock, 0);
      if (b == 64) check("clean_lock_b64", lock, 1);
    end
    check("clean_lock_b70", lock, 1);
    check("clean_no_slip", nslip, 0);
    check("clean_scnt", scnt, 0);

    // table-driven windows
    do_reset("tbl");
    exp_scnt = 0;
    for (int i = 0; i < 11; i++) begin
      run_window(recs[i].n_bad, recs[i].at_end, seen, dok);
      exp_scnt += recs[i].exp_slips;
      check($sformatf("win%0d_lock", i), lock, recs[i].exp_lock);
      check($sformatf("win%0d_slips", i), seen, recs[i].exp_slips);
      check($sformatf("win%0d_scnt", i), scnt, exp_scnt);
      if (recs[i].exp_slips > 0) check($sformatf("win%0d_lock_drop", i), dok, 1);
`ifndef RX_HIBER_MON_EN
      check($sformatf("win%0d_hiber_tied", i), hiber, 0);
`endif
    end

    // slip width and minimum spacing under continuous bad headers
    do_reset("gap");
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      beat(2'b00, 1'b1);
      if (slip) begin got = 1'b1; break; end
    end
    check("gap_first_slip", got, 1);
    check("gap_lock_at_slip", lock, 0);
    check("gap_scnt1", scnt, 1);
    beat(2'b00, 1'b1);
    check("gap_slip_width", slip, 0);
    gap = 1;
    got = 1'b0;
    for (int c = 0; c < 80; c++) begin
      beat(2'b11, 1'b1);
      gap++;
      if (slip) begin got = 1'b1; break; end
    end
    check("gap_second_slip", got, 1);
    check("gap_min_spacing", (gap >= SLIP_WAIT + 2), 1);
    check("gap_scnt2", scnt, 2);

    // reset in the middle of the settle wait
    repeat (10) beat(2'b11, 1'b1);
    do_reset("midwait");
    for (int b = 1; b <= CNT_MAX; b++) begin
      beat(SYNC_CTRL, 1'b1);
      if (b == 63) check("midwait_lock_b63", lock, 0);
    end
    check("midwait_lock_b64", lock, 1);
    check("midwait_scnt", scnt, 0);

    // gearbox model misaligned by 5 bits; each slip moves one bit closer
    do_reset("gbx");
    m = 5;
    nslip = 0;
    got = 1'b0;
    for (int c = 0; c < 600; c++) begin
      h = (m == 0) ? ((c % 2 == 0) ? SYNC_DATA : SYNC_CTRL) : ((m % 2 == 1) ? 2'b11 : 2'b00);
      beat(h, 1'b1);
      if (slip) begin
        nslip++;
        if (m > 0) m--;
      end
      if (lock) begin got = 1'b1; break; end
    end
    check("gbx_locked", got, 1);
    check("gbx_slips_seen", nslip, 5);
    check("gbx_scnt", scnt, 5);

`ifdef RX_HIBER_MON_EN
    do_reset("ber");
    run_window(0, 1'b0, seen, dok);
    check("ber_locked", lock, 1);
    for (int i = 0; i < 3 * BER_WIN; i++) begin
      beat((i < BER_WIN && (i % 6) == 5) ? 2'b11 : SYNC_DATA, 1'b1);
      if (i == 89)  check("ber_before_end", hiber, 0);
      if (i == 109) check("ber_set", hiber, 1);
      if (i == 189) check("ber_held", hiber, 1);
      if (i == 209) check("ber_cleared", hiber, 0);
    end
    check("ber_lock_kept", lock, 1);
`else
    check("hiber_tied_end", hiber, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
